// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   The fetch stage of the toy RV32I core. It sits between the PC controller
//   and decode. It latches the current PC, reads the instruction word from
//   instruction memory over a req/ack handshake, and presents the word to
//   decode on a valid/ready pair. It pulses pc_advance when decode accepts an
//   instruction, so the PC moves only when an instruction is consumed.
//
// Handshakes:
//   imem_req/imem_ack : imem_req is raised with a stable imem_addr. It stays
//                       high until the first cycle in which imem_ack=1, or
//                       until the ack timeout expires. It is never withdrawn
//                       early, not even on flush. imem_rdata is sampled only
//                       in a cycle with imem_ack=1. imem_ack is ignored
//                       outside REQ/WAIT.
//   inst_valid/inst_ready : inst, inst_pc and fetch_fault are valid while
//                       inst_valid=1. They are held stable until decode
//                       accepts with inst_ready=1. inst_ready is ignored
//                       while inst_valid=0.
//
// Ports:
//   clk         in   1     clock, all state updates on posedge
//   rst         in   1     synchronous, active-high reset
//   pc          in   XLEN  current PC from the PC controller
//   flush       in   1     discard the in-flight or held fetch
//   imem_req    out  1     memory read request
//   imem_addr   out  XLEN  memory read address
//   imem_ack    in   1     imem_rdata is valid this cycle
//   imem_rdata  in   XLEN  instruction word from memory
//   inst        out  XLEN  fetched instruction (NOP_INSN when not valid/faulted)
//   inst_pc     out  XLEN  PC of inst
//   inst_valid  out  1     inst/inst_pc/fetch_fault valid for decode
//   inst_ready  in   1     decode accepts inst this cycle
//   fetch_fault out  1     misaligned PC or memory ack timeout
//   pc_advance  out  1     combinational accept pulse to the PC controller
//   fsm_state   out  2     debug view of the FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 VALID)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                XLEN        = 32,
  parameter int                ACK_TIMEOUT = 15,
  parameter logic [XLEN-1:0]   NOP_INSN    = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic            fetch_fault,
  output logic            pc_advance,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  // The counter must be able to hold ACK_TIMEOUT. When the timeout is
  // disabled it is a free-running counter whose value is never used.
  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(ACK_TIMEOUT);

  state_t            state_q;
  logic              req_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   inst_q;
  logic [XLEN-1:0]   inst_pc_q;
  logic              valid_q;
  logic              fault_q;
  logic              drop_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [CNT_W-1:0]  cnt_d;
  logic              drop_d;
  logic              timeout_hit;

  // cnt_d is the number of WAIT cycles including the current one. A timeout
  // therefore fires in the ACK_TIMEOUT-th WAIT cycle, and the fault becomes
  // visible right after that cycle.
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    drop_d      = drop_q | flush;
    timeout_hit = (ACK_TIMEOUT != 0) && (cnt_d == TIMEOUT_VAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      inst_q    <= NOP_INSN;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      drop_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // flush has no effect here: pc already carries any redirect target.
          addr_q    <= pc;
          inst_pc_q <= pc;
          drop_q    <= 1'b0;
          cnt_q     <= '0;
          if (pc[1:0] != 2'b00) begin
            // A misaligned PC is reported without touching memory.
            inst_q  <= NOP_INSN;
            fault_q <= 1'b1;
            valid_q <= 1'b1;
            state_q <= S_VALID;
          end else begin
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end

        S_REQ, S_WAIT: begin
          if (imem_ack) begin
            req_q  <= 1'b0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
            if (drop_d) begin
              // A flush arrived during this fetch, so the returned word is stale.
              state_q <= S_IDLE;
            end else begin
              inst_q  <= imem_rdata;
              fault_q <= 1'b0;
              valid_q <= 1'b1;
              state_q <= S_VALID;
            end
          end else if ((state_q == S_WAIT) && timeout_hit) begin
            req_q  <= 1'b0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
            if (drop_d) begin
              state_q <= S_IDLE;
            end else begin
              inst_q  <= NOP_INSN;
              fault_q <= 1'b1;
              valid_q <= 1'b1;
              state_q <= S_VALID;
            end
          end else begin
            // The request stays asserted. A flush only marks the result for discard.
            drop_q  <= drop_d;
            state_q <= S_WAIT;
            if (state_q == S_WAIT) begin
              cnt_q <= cnt_d;
            end
          end
        end

        S_VALID: begin
          // If flush and inst_ready are both high, flush wins. The exit path
          // is the same for both; only pc_advance tells them apart.
          if (flush || inst_ready) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            inst_q  <= NOP_INSN;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = valid_q;
  assign fetch_fault = fault_q;
  assign fsm_state   = state_q;

  // valid_q is only ever set in VALID, so this pulse needs no state decode.
  assign pc_advance  = valid_q & inst_ready & ~flush;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. The bench plays the instruction memory
// itself. Inputs are driven 1 ns after each rising edge, and outputs are
// checked at that point. Expected values are hand-computed from the
// behaviour description.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        flush;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_fault;
  logic        pc_advance;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit #(
    .XLEN        (32),
    .ACK_TIMEOUT (15),
    .NOP_INSN    (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .fetch_fault (fetch_fault),
    .pc_advance  (pc_advance),
    .fsm_state   (fsm_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_valid_word(input string tag, input logic [31:0] exp_inst,
                                input logic [31:0] exp_pc, input logic exp_fault);
    chk1 ({tag, "_valid"}, inst_valid, 1'b1);
    chk32({tag, "_inst"}, inst, exp_inst);
    chk32({tag, "_pc"}, inst_pc, exp_pc);
    chk1 ({tag, "_fault"}, fetch_fault, exp_fault);
    chk1 ({tag, "_req"}, imem_req, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1 ({tag, "_req"}, imem_req, 1'b0);
    chk32({tag, "_addr"}, imem_addr, 32'h0);
    chk32({tag, "_inst"}, inst, NOP);
    chk32({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk1 ({tag, "_valid"}, inst_valid, 1'b0);
    chk1 ({tag, "_fault"}, fetch_fault, 1'b0);
    chk1 ({tag, "_pc_adv"}, pc_advance, 1'b0);
    chk32({tag, "_state"}, {30'd0, fsm_state}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    pc         = 32'h0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    inst_ready = 1'b0;

    // reset: 2 cycles
    tick();
    tick();
    chk_reset_vals("reset");

    // 1: zero-wait fetch of pc=0
    rst = 1'b0;
    tick();                                   // IDLE -> REQ
    chk1 ("t1_req", imem_req, 1'b1);
    chk32("t1_addr", imem_addr, 32'h0);
    chk1 ("t1_not_valid", inst_valid, 1'b0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h00A0_0093;
    tick();                                   // REQ -> VALID (cycle 3)
    imem_ack   = 1'b0;
    chk_valid_word("t1", 32'h00A0_0093, 32'h0, 1'b0);
    chk1("t1_no_adv_unready", pc_advance, 1'b0);
    inst_ready = 1'b1;
    #1;
    chk1("t1_adv", pc_advance, 1'b1);
    tick();                                   // VALID -> IDLE
    inst_ready = 1'b0;
    #1;
    chk1("t1_idle_valid", inst_valid, 1'b0);
    chk1("t1_idle_adv", pc_advance, 1'b0);

    // 2: ack arrives 4 cycles after req. inst_ready is held high throughout,
    //    which must be ignored until VALID.
    pc         = 32'h0000_0100;
    inst_ready = 1'b1;
    tick();                                   // IDLE -> REQ
    for (int i = 0; i < 4; i++) begin
      chk1 ("t2_req_stable", imem_req, 1'b1);
      chk32("t2_addr_stable", imem_addr, 32'h100);
      chk1 ("t2_adv_ignored", pc_advance, 1'b0);
      tick();
    end
    chk1 ("t2_req_5th", imem_req, 1'b1);
    chk32("t2_addr_5th", imem_addr, 32'h100);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0050_0113;
    tick();                                   // WAIT -> VALID
    imem_ack   = 1'b0;
    #1;
    chk_valid_word("t2", 32'h0050_0113, 32'h100, 1'b0);
    chk1("t2_adv", pc_advance, 1'b1);
    tick();                                   // VALID -> IDLE
    inst_ready = 1'b0;
    #1;
    chk1("t2_single_valid", inst_valid, 1'b0);
    chk1("t2_no_dup_adv", pc_advance, 1'b0);

    // 3: back-pressure for 6 cycles in VALID
    pc = 32'h0000_0104;
    tick();                                   // IDLE -> REQ
    imem_ack   = 1'b1;
    imem_rdata = 32'h0020_81B3;
    tick();                                   // REQ -> VALID
    imem_ack   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk_valid_word("t3_hold", 32'h0020_81B3, 32'h104, 1'b0);
      chk1("t3_hold_adv", pc_advance, 1'b0);
      tick();
    end
    inst_ready = 1'b1;
    #1;
    chk1("t3_adv", pc_advance, 1'b1);
    tick();
    inst_ready = 1'b0;
    #1;
    chk1("t3_released", inst_valid, 1'b0);

    // 4: flush in WAIT cycle 2, late ack with DEADBEEF is discarded
    pc = 32'h0000_0108;
    tick();                                   // IDLE -> REQ
    tick();                                   // REQ -> WAIT1
    chk1("t4_wait1_req", imem_req, 1'b1);
    tick();                                   // WAIT1 -> WAIT2
    flush = 1'b1;
    tick();                                   // WAIT2 with flush
    flush = 1'b0;
    pc    = 32'h0000_8000;
    for (int i = 0; i < 2; i++) begin
      chk1 ("t4_req_held", imem_req, 1'b1);
      chk32("t4_addr_held", imem_addr, 32'h108);
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();                                   // ack consumed, dropped -> IDLE
    imem_ack   = 1'b0;
    #1;
    chk1 ("t4_dropped_valid", inst_valid, 1'b0);
    chk1 ("t4_dropped_req", imem_req, 1'b0);
    chk32("t4_dropped_inst", inst, NOP);
    tick();                                   // IDLE -> REQ for the redirect
    chk1 ("t4_new_req", imem_req, 1'b1);
    chk32("t4_new_addr", imem_addr, 32'h8000);
    chk1 ("t4_new_not_valid", inst_valid, 1'b0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0073;
    tick();
    imem_ack   = 1'b0;
    chk_valid_word("t4_new", 32'h0000_0073, 32'h8000, 1'b0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // 5a: misaligned pc
    pc = 32'h0000_0002;
    tick();                                   // IDLE -> VALID with fault
    chk_valid_word("t5_misalign", NOP, 32'h2, 1'b1);
    inst_ready = 1'b1;
    #1;
    chk1("t5_misalign_adv", pc_advance, 1'b1);
    tick();
    inst_ready = 1'b0;
    #1;
    chk1("t5_misalign_no_req", imem_req, 1'b0);

    // 5b: no ack -> timeout after 15 WAIT cycles
    pc = 32'h0000_0200;
    tick();                                   // IDLE -> REQ
    for (int i = 0; i < 15; i++) begin
      tick();                                 // enters WAIT1 .. WAIT15
      chk1("t5_to_req", imem_req, 1'b1);
      chk1("t5_to_not_valid", inst_valid, 1'b0);
    end
    tick();                                   // WAIT15 times out -> VALID
    chk_valid_word("t5_timeout", NOP, 32'h200, 1'b1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // 6a: flush and inst_ready together in VALID
    pc = 32'h0000_0300;
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack   = 1'b0;
    chk_valid_word("t6", 32'h1234_5678, 32'h300, 1'b0);
    inst_ready = 1'b1;
    flush      = 1'b1;
    #1;
    chk1("t6_flush_beats_ready", pc_advance, 1'b0);
    tick();
    inst_ready = 1'b0;
    flush      = 1'b0;
    #1;
    chk1("t6_flushed_valid", inst_valid, 1'b0);

    // 6b: rst during WAIT
    pc = 32'h0000_0400;
    tick();                                   // IDLE -> REQ
    tick();                                   // REQ -> WAIT1
    tick();                                   // WAIT1 -> WAIT2
    chk1("t6_wait_req", imem_req, 1'b1);
    rst = 1'b1;
    tick();
    chk_reset_vals("t6_rst_wait");
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
